// File: rtl/pipeline_types.sv
// rtl/pipeline_types.sv - shared types and default widths for the cache/memory arbiter
package pipeline_types;

    localparam int LINE_WIDTH_DEF = 256;
    localparam int BEAT_WIDTH_DEF = 32;

    typedef logic [LINE_WIDTH_DEF-1:0] bus256_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        RET,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        WR_ACK
    } arb_state_t;

endpackage

// File: rtl/cache_arb_mem.sv
// rtl/cache_arb_mem.sv - beat-serial memory bus between the arbiter and the AXI-side bridge
interface cache_arb_mem
    import pipeline_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = BEAT_WIDTH_DEF
);

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wlast;
    logic                  bvalid;

    modport master (
        output arvalid, araddr, arlen, awvalid, awaddr, awlen, wvalid, wdata, wlast,
        input  arready, rvalid, rdata, rlast, awready, wready, bvalid
    );

    modport slave (
        input  arvalid, araddr, arlen, awvalid, awaddr, awlen, wvalid, wdata, wlast,
        output arready, rvalid, rdata, rlast, awready, wready, bvalid
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after ptr, wrapping
module rr_arbiter #(
    parameter int NUM_CH = 2,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              grant_valid
);

    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        // Walk offsets from farthest to nearest so the nearest request wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (req[IDX_W'(idx)]) begin
                grant       = NUM_CH'(1) << idx;
                grant_idx   = IDX_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - NUM_CH cache clients (refill, uncached read, writeback) onto one memory bus
module cache_mem_arbiter
    import pipeline_types::*;
#(
    parameter int NUM_CH     = 2,
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int DATA_WIDTH = BEAT_WIDTH_DEF,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_CH-1:0]                 rd_req,
    input  logic [NUM_CH-1:0]                 rd_uncache,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_CH-1:0]                 ret_valid,
    output logic [LINE_WIDTH-1:0]             ret_data,
    input  logic [NUM_CH-1:0]                 wr_req,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_CH-1:0][LINE_WIDTH-1:0] wr_data,
    output logic [NUM_CH-1:0]                 wr_done,
    cache_arb_mem.master                      mem
);

    localparam int BEATS    = LINE_WIDTH / DATA_WIDTH;
    localparam int IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LINE_OFF = $clog2(LINE_WIDTH / 8);
    localparam int WORD_OFF = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << LINE_OFF) - ADDR_WIDTH'(1));
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~((ADDR_WIDTH'(1) << WORD_OFF) - ADDR_WIDTH'(1));
    localparam logic [7:0]            LINE_LEN  = 8'(BEATS - 1);

    arb_state_t            state_q, state_d;
    logic [IDX_W-1:0]      ch_q, ch_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  uncache_q, uncache_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [LINE_WIDTH-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [NUM_CH-1:0]     pending;
    logic [NUM_CH-1:0]     grant;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  grant_wr;
    logic [IDX_W-1:0]      ptr_next;

    assign pending  = rd_req | wr_req;
    assign grant_wr = |(wr_req & grant);
    assign ptr_next = (ch_q == IDX_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
    assign ret_data = buf_q;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
        .req         (pending),
        .ptr         (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        rr_ptr_d    = rr_ptr_q;
        addr_d      = addr_q;
        uncache_d   = uncache_q;
        line_d      = line_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        ret_valid   = '0;
        wr_done     = '0;
        mem.arvalid = 1'b0;
        mem.araddr  = addr_q;
        mem.arlen   = uncache_q ? 8'd0 : LINE_LEN;
        mem.awvalid = 1'b0;
        mem.awaddr  = addr_q;
        mem.awlen   = LINE_LEN;
        mem.wvalid  = 1'b0;
        mem.wdata   = line_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
        mem.wlast   = (cnt_q == CNT_W'(BEATS - 1));

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    ch_d  = grant_idx;
                    cnt_d = '0;
                    // Writeback goes before refill so the victim line leaves before the new one lands.
                    if (grant_wr) begin
                        addr_d    = wr_addr[grant_idx] & LINE_MASK;
                        line_d    = wr_data[grant_idx];
                        uncache_d = 1'b0;
                        state_d   = WR_ADDR;
                    end else begin
                        uncache_d = rd_uncache[grant_idx];
                        addr_d    = rd_addr[grant_idx] & (rd_uncache[grant_idx] ? WORD_MASK : LINE_MASK);
                        buf_d     = '0;
                        state_d   = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                mem.arvalid = 1'b1;
                if (mem.arready) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (mem.rvalid) begin
                    buf_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = mem.rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (mem.rlast) state_d = RET;
                end
            end
            RET: begin
                ret_valid = NUM_CH'(1) << ch_q;
                cnt_d     = '0;
                rr_ptr_d  = ptr_next;
                state_d   = IDLE;
            end
            WR_ADDR: begin
                mem.awvalid = 1'b1;
                if (mem.awready) state_d = WR_DATA;
            end
            WR_DATA: begin
                mem.wvalid = 1'b1;
                if (mem.wready) begin
                    if (mem.wlast) begin
                        cnt_d   = '0;
                        state_d = WR_RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WR_RESP: begin
                if (mem.bvalid) state_d = WR_ACK;
            end
            WR_ACK: begin
                wr_done  = NUM_CH'(1) << ch_q;
                rr_ptr_d = ptr_next;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            rr_ptr_q  <= '0;
            addr_q    <= '0;
            uncache_q <= 1'b0;
            line_q    <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            rr_ptr_q  <= rr_ptr_d;
            addr_q    <= addr_d;
            uncache_q <= uncache_d;
            line_q    <= line_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed checks for cache_mem_arbiter
module tb_cache_mem_arbiter;
    import pipeline_types::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        rd_req, rd_uncache, wr_req, ret_valid, wr_done;
    logic [1:0][31:0]  rd_addr, wr_addr;
    logic [1:0][255:0] wr_data;
    bus256_t           ret_data;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int ret_cnt [2] = '{0, 0};
    int wr_cnt  [2] = '{0, 0};

    cache_arb_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

    cache_mem_arbiter #(.NUM_CH(2), .LINE_WIDTH(256), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_req     (rd_req),
        .rd_uncache (rd_uncache),
        .rd_addr    (rd_addr),
        .ret_valid  (ret_valid),
        .ret_data   (ret_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .mem        (mem_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ret_valid[i]) ret_cnt[i] <= ret_cnt[i] + 1;
            if (wr_done[i])   wr_cnt[i]  <= wr_cnt[i] + 1;
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_arvalid();
        for (int g = 0; g < 50 && mem_if.arvalid !== 1'b1; g++) @(negedge clk);
        check("arvalid_seen", mem_if.arvalid, 1'b1);
    endtask

    // Serve one read burst; returns at the negedge where the arbiter is in RET.
    task automatic serve_read(input int nbeats, input logic [31:0] seed, input logic [31:0] exp_addr,
                              input logic [7:0] exp_len, output bus256_t exp_buf);
        wait_arvalid();
        check("araddr", mem_if.araddr, exp_addr);
        check("arlen", mem_if.arlen, exp_len);
        @(negedge clk);
        exp_buf = '0;
        for (int i = 0; i < nbeats; i++) begin
            mem_if.rvalid = 1'b1;
            mem_if.rdata  = seed + 32'(i);
            mem_if.rlast  = (i == nbeats - 1);
            exp_buf[i*32 +: 32] = seed + 32'(i);
            @(negedge clk);
        end
        mem_if.rvalid = 1'b0;
        mem_if.rlast  = 1'b0;
    endtask

    // Serve one writeback; returns at the negedge where the arbiter is in WR_ACK.
    task automatic serve_write(input logic [1:0] exp_done, input bit stall, input logic [31:0] exp_addr,
                               input bus256_t exp_line);
        int got = 0;
        int guard = 0;
        bit toggle = 1'b1;
        bit stalled = 1'b0;
        logic [31:0] held = '0;
        for (int g = 0; g < 50 && mem_if.awvalid !== 1'b1; g++) @(negedge clk);
        check("awvalid_seen", mem_if.awvalid, 1'b1);
        check("awaddr", mem_if.awaddr, exp_addr);
        check("awlen", mem_if.awlen, 8'd7);
        @(negedge clk);
        while (got < 8 && guard < 100) begin
            guard++;
            check("wvalid", mem_if.wvalid, 1'b1);
            check("wlast", mem_if.wlast, (got == 7));
            if (stalled) check("w_hold", mem_if.wdata, held);
            mem_if.wready = stall ? toggle : 1'b1;
            toggle = ~toggle;
            if (mem_if.wready) begin
                check("wdata", mem_if.wdata, exp_line[got*32 +: 32]);
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held = mem_if.wdata;
            end
            @(negedge clk);
        end
        mem_if.wready = 1'b0;
        check("w_beats", got, 8);
        check("wvalid_in_resp", mem_if.wvalid, 1'b0);
        check("wr_done_early", wr_done, 2'b00);
        mem_if.bvalid = 1'b1;
        @(negedge clk);
        mem_if.bvalid = 1'b0;
        check("wr_done", wr_done, exp_done);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal;
    end

    initial begin
        bus256_t rbuf;
        int c0;
        int rc;
        mem_if.arready = 1'b1;
        mem_if.awready = 1'b1;
        mem_if.rvalid  = 1'b0;
        mem_if.rdata   = '0;
        mem_if.rlast   = 1'b0;
        mem_if.wready  = 1'b0;
        mem_if.bvalid  = 1'b0;
        rd_req = '0; rd_uncache = '0; rd_addr = '0;
        wr_req = '0; wr_addr = '0; wr_data = '0;

        repeat (2) @(negedge clk);
        check("rst_ret_valid", ret_valid, 2'b00);
        check("rst_wr_done", wr_done, 2'b00);
        check("rst_ret_data", ret_data, '0);
        check("rst_arvalid", mem_if.arvalid, 1'b0);
        check("rst_awvalid", mem_if.awvalid, 1'b0);
        check("rst_wvalid", mem_if.wvalid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: ch0 cached refill, zero-wait
        rd_addr[0] = 32'h1C00_0014;
        rd_req[0]  = 1'b1;
        c0 = cyc;
        serve_read(8, 32'h0, 32'h1C00_0000, 8'd7, rbuf);
        check("t1_latency", cyc - c0, 10);
        check("t1_ret_valid", ret_valid, 2'b01);
        check("t1_ret_data", ret_data, 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        rd_req[0] = 1'b0;
        @(negedge clk);
        check("t1_pulse_once", ret_valid, 2'b00);
        check("t1_ret_cnt", ret_cnt[0], 1);
        check("t1_ret_data_held", ret_data, rbuf);

        // 2: ch1 uncached word
        rd_addr[1] = 32'hBFAF_8002;
        rd_uncache[1] = 1'b1;
        rd_req[1] = 1'b1;
        serve_read(1, 32'hDEAD_BEEF, 32'hBFAF_8000, 8'd0, rbuf);
        check("t2_ret_valid", ret_valid, 2'b10);
        check("t2_ret_data", ret_data, 256'hDEAD_BEEF);
        rd_req[1] = 1'b0;
        @(negedge clk);
        check("t2_ret_cnt1", ret_cnt[1], 1);
        check("t2_ret_cnt0", ret_cnt[0], 1);

        // 3: ch1 writeback and refill together, write first
        wr_addr[1] = 32'h0000_1234;
        wr_data[1] = {8{32'hAAAA_AAAA}};
        rd_addr[1] = 32'h2000_0044;
        rd_uncache[1] = 1'b0;
        wr_req[1] = 1'b1;
        rd_req[1] = 1'b1;
        serve_write(2'b10, 1'b0, 32'h0000_1220, {8{32'hAAAA_AAAA}});
        wr_req[1] = 1'b0;
        serve_read(8, 32'h100, 32'h2000_0040, 8'd7, rbuf);
        check("t3_ret_valid", ret_valid, 2'b10);
        check("t3_ret_data", ret_data, rbuf);
        rd_req[1] = 1'b0;

        // 4: both channels reading continuously -> 0,1,0,1
        rd_uncache = 2'b11;
        rd_addr[0] = 32'h1000_0006;
        rd_addr[1] = 32'h2000_000B;
        rd_req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            serve_read(1, 32'h40 + 32'(t), (t % 2 == 1) ? 32'h2000_0008 : 32'h1000_0004, 8'd0, rbuf);
            check("t4_ret_valid", ret_valid, (t % 2 == 1) ? 2'b10 : 2'b01);
        end
        rd_req = 2'b00;

        // 5: ch0 writeback with wready toggling
        wr_addr[0] = 32'h4000_007C;
        for (int i = 0; i < 8; i++) wr_data[0][i*32 +: 32] = 32'h5000_0000 + 32'(i);
        wr_req[0] = 1'b1;
        serve_write(2'b01, 1'b1, 32'h4000_0060,
                    256'h50000007_50000006_50000005_50000004_50000003_50000002_50000001_50000000);
        wr_req[0] = 1'b0;
        @(negedge clk);
        check("t5_wr_cnt0", wr_cnt[0], 1);
        check("t5_wr_cnt1", wr_cnt[1], 1);

        // 6: reset during beat 3 of a refill
        rd_uncache = 2'b00;
        rd_addr[0] = 32'h3000_0000;
        rd_req = 2'b01;
        wait_arvalid();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mem_if.rvalid = 1'b1;
            mem_if.rdata  = 32'(i);
            @(negedge clk);
        end
        mem_if.rdata = 32'h3;
        rst_n = 1'b0;
        #1;
        check("t6_ret_valid", ret_valid, 2'b00);
        check("t6_ret_data", ret_data, '0);
        check("t6_arvalid", mem_if.arvalid, 1'b0);
        check("t6_awvalid", mem_if.awvalid, 1'b0);
        check("t6_wvalid", mem_if.wvalid, 1'b0);
        check("t6_wr_done", wr_done, 2'b00);
        mem_if.rvalid = 1'b0;
        rd_req = 2'b00;
        rc = ret_cnt[0];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_no_pulse", ret_cnt[0], rc);
        rd_uncache = 2'b11;
        rd_addr[0] = 32'h3000_0010;
        rd_addr[1] = 32'h3100_0020;
        rd_req = 2'b11;
        serve_read(1, 32'h77, 32'h3000_0010, 8'd0, rbuf);
        check("t6_ret_valid_ch0", ret_valid, 2'b01);
        check("t6_ret_data_ch0", ret_data, 256'h77);
        rd_req[0] = 1'b0;
        serve_read(1, 32'h88, 32'h3100_0020, 8'd0, rbuf);
        check("t6_ret_valid_ch1", ret_valid, 2'b10);
        check("t6_ret_data_ch1", ret_data, 256'h88);
        rd_req = 2'b00;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
